apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB read/write data width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, access-phase wait-state limit; used only with APB_MASTER_TIMEOUT_EN.
REQ-004 SHALL have ports, one per line:
- clk_i  input  1  sole clock; all state on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  1  command valid.
- req_ready_o  output  1  command accepted when valid and ready both high.
- req_addr_i  input  ADDR_WIDTH  target address.
- req_write_i  input  1  1 = write, 0 = read.
- req_wdata_i  input  DATA_WIDTH  write data.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumed when valid and ready both high.
- rsp_rdata_o  output  DATA_WIDTH  read data; 0 for writes.
- rsp_err_o  output  1  slave error or timeout.
- paddr_o  output  ADDR_WIDTH  APB address.
- psel_o  output  1  APB select.
- penable_o  output  1  APB enable.
- pwrite_o  output  1  APB direction.
- pwdata_o  output  DATA_WIDTH  APB write data.
- pclk_o  output  1  APB clock; driven combinationally as clk_i.
- pready_i  input  1  APB ready.
- prdata_i  input  DATA_WIDTH  APB read data.
- pslverr_i  input  1  APB slave error.
REQ-005 SHALL drive the APB-side ports so they connect one-to-one to the Master modport of the APB interface.

Function
REQ-006 SHALL implement the states IDLE, SETUP, ACCESS and RESP, with all outputs except pclk_o and req_ready_o registered.
REQ-007 SHALL assert req_ready_o only in IDLE; a handshake there latches addr, write and wdata and moves to SETUP.
REQ-008 SHALL in SETUP drive psel_o=1 and penable_o=0 for exactly one cycle, then move to ACCESS.
REQ-009 SHALL in ACCESS drive psel_o=1 and penable_o=1, holding paddr_o, pwrite_o and pwdata_o stable until the transfer completes.
REQ-010 SHALL on an ACCESS cycle with pready_i=1 capture prdata_i (reads) or 0 (writes) into rsp_rdata_o and pslverr_i into rsp_err_o, deassert psel_o/penable_o, and enter RESP.
REQ-011 SHALL in RESP hold rsp_valid_o=1 with stable rsp_rdata_o/rsp_err_o until rsp_ready_i=1, then return to IDLE.
REQ-012 SHALL achieve minimum latency, with pready_i=1 on the first ACCESS cycle, of: handshake cycle N, SETUP N+1, ACCESS N+2, rsp_valid_o=1 at N+3.
REQ-013 SHALL hold psel_o low for at least one cycle between back-to-back transfers; no request is accepted while a response is pending.
REQ-014 SHALL ignore pready_i, prdata_i and pslverr_i outside ACCESS.
REQ-015 SHALL keep paddr_o and pwdata_o at their last values when idle, so they only change on a new SETUP.

Reset
REQ-016 SHALL on rst_i=1, immediately and regardless of clk_i, enter IDLE and clear psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o, rsp_rdata_o, rsp_err_o and the timeout counter.
REQ-017 SHALL on reset during SETUP, ACCESS or RESP abandon the transfer without producing a response; the first cycle after release is IDLE with req_ready_o=1.

Configuration
REQ-018 SHALL, with macro APB_MASTER_TIMEOUT_EN defined, count ACCESS cycles with pready_i=0; when the count reaches TIMEOUT_CYCLES it SHALL end the transfer (psel_o/penable_o=0) and enter RESP with rsp_err_o=1 and rsp_rdata_o=0.
REQ-019 SHALL reset the timeout counter on every entry to SETUP.
REQ-020 SHALL, with APB_MASTER_TIMEOUT_EN undefined, wait in ACCESS indefinitely, include no counter logic, and ignore TIMEOUT_CYCLES.

Verification
REQ-021 SHALL cover a write: addr 0x0000_1004, wdata 0xDEAD_BEEF, pready=1 immediately -> SETUP then ACCESS with pwrite=1, rsp_valid at handshake+3, rsp_err=0, rsp_rdata=0.
REQ-022 SHALL cover a read: addr 0x0000_2000, slave inserts 3 wait states then returns 0x1234_5678 -> penable high for 4 cycles, rsp_rdata=0x1234_5678, paddr stable throughout.
REQ-023 SHALL cover pslverr=1 on a read completing with prdata 0xFFFF_FFFF -> rsp_err=1, rsp_rdata=0xFFFF_FFFF; a following transfer starts cleanly.
REQ-024 SHALL cover response backpressure: rsp_ready low 5 cycles -> rsp_valid and data stable, req_ready=0 and psel=0 throughout.
REQ-025 SHALL cover timeout: with APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0 -> psel drops after 4 ACCESS cycles and rsp_err=1; without the macro, psel stays high for 100 cycles.
REQ-026 SHALL cover reset asserted mid-ACCESS -> psel/penable drop asynchronously, no rsp_valid, and req_ready=1 after release.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding request/response to APB master bridge; optional access timeout under APB_MASTER_TIMEOUT_EN
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic                  pclk_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t                r_state;
  logic                  r_psel, r_penable, r_pwrite, r_rsp_valid, r_rsp_err;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata, r_rsp_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;
  logic          w_tmo_hit;
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYCLES;
`endif
  assign pclk_o      = clk_i;
  assign req_ready_o = (r_state == IDLE);
  assign psel_o      = r_psel;
  assign penable_o   = r_penable;
  assign pwrite_o    = r_pwrite;
  assign paddr_o     = r_paddr;
  assign pwdata_o    = r_pwdata;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  // Sequence one command through SETUP and ACCESS, then hold its response until consumed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (req_valid_i) begin
          r_state  <= SETUP;
          r_psel   <= 1'b1;
          r_paddr  <= req_addr_i;
          r_pwrite <= req_write_i;
          r_pwdata <= req_wdata_i;
`ifdef APB_MASTER_TIMEOUT_EN
          r_tmo    <= '0;
`endif
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: if (pready_i) begin
          r_state     <= RESP;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_pwrite ? '0 : prdata_i;
          r_rsp_err   <= pslverr_i;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (w_tmo_hit) begin
          r_state     <= RESP;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b1;
        end else r_tmo <= r_tmo + TW'(1);
`endif
        RESP: if (rsp_ready_i) begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized and directed checks of apb_master_bridge against a transfer-timing model
module tb_apb_master_bridge;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int STALL = TMO_EN ? 2 : 100;
  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0, pready = 1'b0, pslverr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, prdata = '0;
  logic          req_ready_o, rsp_valid_o, rsp_err_o, psel_o, penable_o, pwrite_o, pclk_o;
  logic [DW-1:0] rsp_rdata_o, pwdata_o;
  logic [AW-1:0] paddr_o;
  always #5 clk = ~clk;
  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pclk_o(pclk_o), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );
  int n_vec = 0, n_err = 0, cyc = 0, hs_cyc = 0;
  // model: an active transfer is described by k = cycles since its handshake and its effective wait count
  bit            m_act = 1'b0;
  int            m_k = 0, m_w = 0, s_w = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0, s_rdata = '0;
  logic          m_write = 1'b0, m_err = 1'b0, s_err = 1'b0;
  bit            rnd = 1'b0, q_go = 1'b0;
  logic [AW-1:0] q_addr = '0;
  logic [DW-1:0] q_wdata = '0, q_rdata = '0;
  logic          q_write = 1'b0, q_err = 1'b0;
  int            q_w = 0, q_hold = 0;
  int            o_rv, o_pen, o_psel, o_addr_bad, o_rvcnt;
  logic [DW-1:0] o_rdata;
  logic          o_err;
  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endfunction
  task automatic compare();
    bit ps, pe, rv;
    ps = m_act && m_k <= 2 + m_w;
    pe = m_act && m_k >= 2 && m_k <= 2 + m_w;
    rv = m_act && m_k >= 3 + m_w;
    chk("req_ready", req_ready_o, !m_act);
    chk("psel", psel_o, ps);
    chk("penable", penable_o, pe);
    chk("rsp_valid", rsp_valid_o, rv);
    chk("paddr", paddr_o, m_addr);
    chk("pwdata", pwdata_o, m_wdata);
    chk("pwrite", pwrite_o, m_write);
    if (rv) begin
      chk("rsp_rdata", rsp_rdata_o, m_rdata);
      chk("rsp_err", rsp_err_o, m_err);
    end
  endtask
  task automatic drive();
    if (rnd) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_addr  = $urandom;
      req_write = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
      rsp_ready = 1'($urandom_range(0, 1));
    end else begin
      req_valid = q_go || (m_act && $urandom_range(0, 1) == 1);
      req_addr  = q_go ? q_addr : $urandom;
      req_write = q_go ? q_write : 1'($urandom_range(0, 1));
      req_wdata = q_go ? q_wdata : $urandom;
      rsp_ready = m_act ? (m_k >= 3 + m_w + q_hold) : 1'($urandom_range(0, 1));
    end
    if (m_act && m_k == 2 + s_w) begin
      pready = 1'b1; prdata = s_rdata; pslverr = s_err;
    end else if (m_act && m_k >= 2 && m_k < 2 + s_w) begin
      pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
    end else begin
      pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic update();
    if (!m_act) begin
      if (req_valid) begin
        m_act = 1'b1; m_k = 1; hs_cyc = cyc;
        m_addr = req_addr; m_write = req_write; m_wdata = req_wdata;
        if (q_go) begin
          s_w = q_w; s_rdata = q_rdata; s_err = q_err;
        end else begin
          s_w = $urandom_range(0, 3); s_rdata = $urandom; s_err = ($urandom_range(0, 3) == 0);
        end
        q_go = 1'b0;
        m_w = s_w; m_rdata = m_write ? '0 : s_rdata; m_err = s_err;
        if (TMO_EN && s_w >= TMO) begin
          m_w = TMO - 1; m_rdata = '0; m_err = 1'b1;
        end
      end
    end else if (m_k >= 3 + m_w && rsp_ready) m_act = 1'b0;
    else m_k++;
  endtask
  task automatic tick();
    drive();
    @(posedge clk);
    cyc++;
    update();
    #1;
    compare();
  endtask
  task automatic run_xfer(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd, input int w,
                          input logic [DW-1:0] rd, input logic er, input int hold);
    bit started = 1'b0, done = 1'b0;
    rnd = 1'b0; q_addr = a; q_write = wr; q_wdata = wd; q_w = w; q_rdata = rd; q_err = er; q_hold = hold; q_go = 1'b1;
    o_rv = -1; o_pen = 0; o_psel = 0; o_addr_bad = 0; o_rvcnt = 0; o_rdata = '0; o_err = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (m_act) started = 1'b1;
      if (psel_o) begin
        o_psel++;
        if (paddr_o !== a) o_addr_bad++;
      end
      if (penable_o) o_pen++;
      if (rsp_valid_o) begin
        o_rvcnt++;
        if (o_rv < 0) begin
          o_rv = cyc - hs_cyc + 1; o_rdata = rsp_rdata_o; o_err = rsp_err_o;
        end
      end
      if (started && !m_act) done = 1'b1;
    end
    chk("xfer_done", done, 1);
  endtask
  task automatic stall_reset();
    bit ok = 1'b0;
    int np = 0;
    rnd = 1'b0; q_addr = 32'h0000_3000; q_write = 1'b0; q_wdata = $urandom; q_w = 1000;
    q_rdata = $urandom; q_err = 1'b0; q_hold = 0; q_go = 1'b1;
    for (int i = 0; i < STALL + 20 && !ok; i++) begin
      tick();
      if (psel_o) np++;
      if (m_act && m_k == 1 + STALL) ok = 1'b1;
    end
    chk("stall_reached", ok, 1);
    chk("stall_psel_cycles", np, STALL + 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_psel", psel_o, 0);
    chk("rst_async_penable", penable_o, 0);
    chk("rst_async_rsp_valid", rsp_valid_o, 0);
    m_act = 1'b0; m_addr = '0; m_wdata = '0; m_write = 1'b0; q_go = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_rel_ready", req_ready_o, 1);
    chk("rst_rel_rsp_valid", rsp_valid_o, 0);
    chk("rst_rel_paddr", paddr_o, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_psel", psel_o, 0);
    chk("reset_penable", penable_o, 0);
    chk("reset_pwrite", pwrite_o, 0);
    chk("reset_paddr", paddr_o, 0);
    chk("reset_pwdata", pwdata_o, 0);
    chk("reset_rsp_valid", rsp_valid_o, 0);
    chk("reset_rsp_rdata", rsp_rdata_o, 0);
    chk("reset_rsp_err", rsp_err_o, 0);
    chk("reset_req_ready", req_ready_o, 1);
    chk("pclk_high", pclk_o, 1);
    #5;
    chk("pclk_low", pclk_o, 0);
    #2 rst = 1'b0;
    run_xfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 0);
    chk("wr_latency", o_rv, 3);
    chk("wr_rdata", o_rdata, 0);
    chk("wr_err", o_err, 0);
    chk("wr_penable_cycles", o_pen, 1);
    run_xfer(32'h0000_2000, 1'b0, $urandom, 3, 32'h1234_5678, 1'b0, 0);
    chk("rd_penable_cycles", o_pen, 4);
    chk("rd_rdata", o_rdata, 32'h1234_5678);
    chk("rd_addr_stable", o_addr_bad, 0);
    chk("rd_latency", o_rv, 6);
    run_xfer(32'h0000_2004, 1'b0, '0, 1, 32'hFFFF_FFFF, 1'b1, 0);
    chk("err_flag", o_err, 1);
    chk("err_rdata", o_rdata, 32'hFFFF_FFFF);
    run_xfer(32'h0000_2008, 1'b1, 32'h5555_AAAA, 0, '0, 1'b0, 0);
    chk("after_err_latency", o_rv, 3);
    chk("after_err_flag", o_err, 0);
    run_xfer(32'h0000_300C, 1'b0, '0, 2, 32'hCAFE_F00D, 1'b0, 5);
    chk("bp_valid_cycles", o_rvcnt, 6);
    chk("bp_rdata", o_rdata, 32'hCAFE_F00D);
`ifdef APB_MASTER_TIMEOUT_EN
    run_xfer(32'h0000_4000, 1'b0, '0, 1000, 32'h0000_1111, 1'b0, 0);
    chk("tmo_psel_cycles", o_psel, TMO + 1);
    chk("tmo_penable_cycles", o_pen, TMO);
    chk("tmo_err", o_err, 1);
    chk("tmo_rdata", o_rdata, 0);
`endif
    rnd = 1'b1;
    repeat (2000) tick();
    rnd = 1'b0; q_hold = 0; q_go = 1'b0;
    for (int i = 0; i < 100 && m_act; i++) tick();
    chk("drain_idle", m_act, 0);
    stall_reset();
    rnd = 1'b1;
    repeat (300) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
